// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst/response encodings, FSM state types and CLOG2 helper
package axi_pkg;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
    function automatic int CLOG2(input int v);
        CLOG2 = 0;
        while ((1 << CLOG2) < v) CLOG2++;
    endfunction
endpackage

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: next beat address for FIXED/INCR/WRAP bursts plus illegal-burst flag
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BYTES      = 4
)(
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  illegal
);
    logic                  wrap_ok;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;
    assign wrap_ok   = len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    assign incr      = addr + ADDR_WIDTH'(BYTES);
    assign mask      = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * ADDR_WIDTH'(BYTES) - ADDR_WIDTH'(1);
    assign illegal   = burst == 2'd3 || (burst == BURST_WRAP && !wrap_ok);
    assign next_addr = burst == BURST_FIXED ? addr :
                       (burst == BURST_WRAP && wrap_ok) ? (addr & ~mask) | (incr & mask) : incr;
endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI3 memory slave with independent write/read FSMs; AXI_SLAVE_RAND_STALL_EN adds random stalls
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int ID_WIDTH   = 4
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [ID_WIDTH-1:0]     i_wid,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrobe,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [ID_WIDTH-1:0]     o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [1:0]              i_arburst,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready
);
    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int IDX_LSB = CLOG2(BYTES);
    localparam int IDX_W   = CLOG2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rd_dec, live, stall, hold_b, hold_r, unused_wid;
    w_state_e              w_state, w_state_n;
    r_state_e              r_state, r_state_n;
    logic [ID_WIDTH-1:0]   aw_id, ar_id;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr, w_next_addr, r_next_addr, r_sel;
    logic [7:0]            aw_len, ar_len, w_cnt, r_cnt;
    logic [1:0]            aw_burst, ar_burst;
    logic                  w_dec, w_slv, w_last_seen, w_illegal, r_illegal;
    logic                  aw_hs, w_hs, ar_hs, r_hs, w_end, r_end, w_oob, r_en;
    assign unused_wid = ^i_wid;
    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .BYTES(BYTES)) u_w_addr (
        .addr(aw_addr), .len(aw_len), .burst(aw_burst), .next_addr(w_next_addr), .illegal(w_illegal)
    );
    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .BYTES(BYTES)) u_r_addr (
        .addr(ar_addr), .len(ar_len), .burst(ar_burst), .next_addr(r_next_addr), .illegal(r_illegal)
    );
`ifdef AXI_SLAVE_RAND_STALL_EN
    logic [15:0] lfsr;
    logic [1:0]  b_dly, r_dly;
    assign stall  = lfsr[1:0] == 2'd0;
    assign hold_b = b_dly != 2'd0;
    assign hold_r = r_dly != 2'd0;
    // free-running LFSR; each new valid gets a fresh 0-3 cycle delay that only counts down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr  <= 16'hACE1;
            b_dly <= '0;
            r_dly <= '0;
        end else begin
            lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            b_dly <= w_state != W_RESP ? lfsr[3:2] : hold_b ? b_dly - 2'd1 : b_dly;
            r_dly <= (r_state != R_DATA || r_hs) ? lfsr[3:2] : hold_r ? r_dly - 2'd1 : r_dly;
        end
    end
`else
    assign stall  = 1'b0;
    assign hold_b = 1'b0;
    assign hold_r = 1'b0;
`endif
    assign o_awready = live && !stall && w_state == W_IDLE;
    assign o_wready  = live && !stall && w_state == W_DATA;
    assign o_bvalid  = w_state == W_RESP && !hold_b;
    assign o_bid     = aw_id;
    assign o_bresp   = w_state != W_RESP ? RESP_OKAY : w_dec ? RESP_DECERR : w_slv ? RESP_SLVERR : RESP_OKAY;
    assign o_arready = live && !stall && r_state == R_IDLE;
    assign o_rvalid  = r_state == R_DATA && !hold_r;
    assign o_rid     = ar_id;
    assign o_rdata   = (r_state == R_DATA && !rd_dec) ? rd_q : '0;
    assign o_rresp   = r_state != R_DATA ? RESP_OKAY : rd_dec ? RESP_DECERR : r_illegal ? RESP_SLVERR : RESP_OKAY;
    assign o_rlast   = r_state == R_DATA && r_end;
    assign aw_hs = i_awvalid && o_awready;
    assign w_hs  = i_wvalid && o_wready;
    assign ar_hs = i_arvalid && o_arready;
    assign r_hs  = o_rvalid && i_rready;
    assign w_end = w_cnt == aw_len;
    assign r_end = r_cnt == ar_len;
    assign w_oob = {1'b0, aw_addr} >= MEM_BYTES;
    assign r_sel = ar_hs ? i_araddr : r_next_addr;
    assign r_en  = ar_hs || (r_hs && !r_end);
    // state registers plus the flag that keeps readies low until reset has been released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            live    <= 1'b0;
        end else begin
            w_state <= w_state_n;
            r_state <= r_state_n;
            live    <= 1'b1;
        end
    end
    // write FSM next state
    always_comb begin
        w_state_n = w_state;
        if (w_state == W_IDLE && aw_hs) w_state_n = W_DATA;
        if (w_state == W_DATA && w_hs && w_end) w_state_n = W_RESP;
        if (w_state == W_RESP && o_bvalid && i_bready) w_state_n = W_IDLE;
    end
    // read FSM next state; FETCH covers the one-cycle RAM latency
    always_comb begin
        r_state_n = r_state;
        if (r_state == R_IDLE && ar_hs) r_state_n = R_FETCH;
        if (r_state == R_FETCH) r_state_n = R_DATA;
        if (r_state == R_DATA && r_hs && r_end) r_state_n = R_IDLE;
    end
    // write burst tracking and error flag accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_id       <= '0;
            aw_addr     <= '0;
            aw_len      <= '0;
            aw_burst    <= '0;
            w_cnt       <= '0;
            w_dec       <= 1'b0;
            w_slv       <= 1'b0;
            w_last_seen <= 1'b0;
        end else if (aw_hs) begin
            aw_id       <= i_awid;
            aw_addr     <= i_awaddr;
            aw_len      <= i_awlen;
            aw_burst    <= i_awburst;
            w_cnt       <= '0;
            w_dec       <= 1'b0;
            w_slv       <= 1'b0;
            w_last_seen <= 1'b0;
        end else if (w_hs) begin
            aw_addr     <= w_next_addr;
            w_cnt       <= w_cnt + 8'd1;
            w_dec       <= w_dec | w_oob;
            w_slv       <= w_slv | w_illegal | (w_end && (!i_wlast || w_last_seen));
            w_last_seen <= w_last_seen | i_wlast;
        end
    end
    // read burst tracking; the decode error travels with the fetched word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_burst <= '0;
            r_cnt    <= '0;
            rd_dec   <= 1'b0;
        end else begin
            if (ar_hs) begin
                ar_id    <= i_arid;
                ar_addr  <= i_araddr;
                ar_len   <= i_arlen;
                ar_burst <= i_arburst;
                r_cnt    <= '0;
            end else if (r_hs) begin
                ar_addr  <= r_next_addr;
                r_cnt    <= r_cnt + 8'd1;
            end
            if (r_en) rd_dec <= {1'b0, r_sel} >= MEM_BYTES;
        end
    end
    // RAM: byte-masked write, registered read-first port
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++)
            if (w_hs && !w_oob && i_wstrobe[i]) mem[aw_addr[IDX_LSB +: IDX_W]][8*i +: 8] <= i_wdata[8*i +: 8];
        if (r_en) rd_q <= mem[r_sel[IDX_LSB +: IDX_W]];
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed table plus burst/backpressure/reset sequences for axi_slave_mem
module tb_axi_slave_mem;
    import axi_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  i_awid = '0, i_wid = '0, i_arid = '0, o_bid, o_rid;
    logic [31:0] i_awaddr = '0, i_araddr = '0, i_wdata = '0, o_rdata;
    logic [7:0]  i_awlen = '0, i_arlen = '0;
    logic [1:0]  i_awburst = '0, i_arburst = '0, o_bresp, o_rresp;
    logic [3:0]  i_wstrobe = '0;
    logic        i_awvalid = 0, i_wlast = 0, i_wvalid = 0, i_bready = 0, i_arvalid = 0, i_rready = 0;
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rlast, o_rvalid;
    logic [49:0] all_out;
    int          checks = 0, failures = 0;
    logic [31:0] wbuf [16];
    logic [31:0] ebuf [16];
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } vec_t;
    vec_t vecs [13];

    always #5 clk = ~clk;

    axi_slave_mem dut (
        .clk(clk), .rst_n(rst_n),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awburst(i_awburst),
        .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wid(i_wid), .i_wdata(i_wdata), .i_wstrobe(i_wstrobe), .i_wlast(i_wlast),
        .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arburst(i_arburst),
        .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready)
    );

    assign all_out = {o_awready, o_wready, o_bid, o_bresp, o_bvalid, o_arready,
                      o_rid, o_rdata, o_rresp, o_rlast, o_rvalid};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input logic [3:0] strb,
                            input logic [15:0] lastm, input int bstall, input logic [1:0] eresp);
        int n;
        i_awid = id; i_awaddr = addr; i_awlen = len; i_awburst = burst; i_awvalid = 1;
        n = 0;
        while (!o_awready && n < 50) begin @(negedge clk); n++; end
        check({tag, "_aw_timeout"}, n < 50, 1);
        @(negedge clk);
        i_awvalid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            i_wdata = wbuf[i]; i_wstrobe = strb; i_wlast = lastm[i]; i_wvalid = 1;
            n = 0;
            while (!o_wready && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        i_wvalid = 0; i_wlast = 0;
        n = 0;
        while (!o_bvalid && n < 50) begin @(negedge clk); n++; end
        check({tag, "_b_timeout"}, n < 50, 1);
        for (int k = 0; k < bstall; k++) begin
            @(negedge clk);
            check({tag, "_bhold"}, {o_bvalid, o_bresp, o_bid}, {1'b1, eresp, id});
        end
        check({tag, "_bresp"}, o_bresp, eresp);
        check({tag, "_bid"}, o_bid, id);
        i_bready = 1;
        @(negedge clk);
        i_bready = 0;
        check({tag, "_bdone"}, {o_bvalid, o_awready}, 2'b01);
    endtask

    // first beat is expected one sampled cycle after the AR handshake cycle (rvalid 2 cycles after it)
    task automatic do_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst, input logic [1:0] eresp,
                           input int stall_beat, input int stall_cyc);
        int n, beat, lat, span;
        i_arid = id; i_araddr = addr; i_arlen = len; i_arburst = burst; i_arvalid = 1; i_rready = 1;
        n = 0;
        while (!o_arready && n < 50) begin @(negedge clk); n++; end
        check({tag, "_ar_timeout"}, n < 50, 1);
        @(negedge clk);
        i_arvalid = 0;
        lat = 0;
        while (!o_rvalid && lat < 50) begin lat++; @(negedge clk); end
        check({tag, "_latency"}, lat, 1);
        beat = 0; span = 0; n = 0;
        while (beat <= int'(len) && n < 100) begin
            n++;
            span++;
            if (o_rvalid) begin
                if (beat == stall_beat) begin
                    i_rready = 0;
                    for (int k = 0; k < stall_cyc; k++) begin
                        @(negedge clk);
                        check({tag, "_rhold"}, {o_rvalid, o_rdata, o_rid, o_rlast},
                              {1'b1, ebuf[beat], id, beat == int'(len)});
                    end
                    i_rready = 1;
                end
                check($sformatf("%s_rdata%0d", tag, beat), o_rdata, ebuf[beat]);
                check($sformatf("%s_rresp%0d", tag, beat), o_rresp, eresp);
                check($sformatf("%s_rlast%0d", tag, beat), o_rlast, beat == int'(len));
                check($sformatf("%s_rid%0d", tag, beat), o_rid, id);
                beat++;
            end
            @(negedge clk);
        end
        i_rready = 0;
        check({tag, "_beats"}, beat, int'(len) + 1);
        if (stall_beat < 0) check({tag, "_stream"}, span, int'(len) + 1);
        check({tag, "_rdone"}, {o_rvalid, o_arready}, 2'b01);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0000, BURST_INCR + 2'd2, 32'h600D_CAFE, 4'hF, RESP_SLVERR};
        vecs[1]  = '{1'b1, 32'h0000_1000, BURST_INCR, 32'hDEAD_BEEF, 4'hF, RESP_DECERR};
        vecs[2]  = '{1'b0, 32'h0000_0000, BURST_INCR, 32'h600D_CAFE, 4'h0, RESP_OKAY};
        vecs[3]  = '{1'b0, 32'h0000_0000, 2'd3,       32'h600D_CAFE, 4'h0, RESP_SLVERR};
        vecs[4]  = '{1'b0, 32'h0000_1000, BURST_INCR, 32'h0000_0000, 4'h0, RESP_DECERR};
        vecs[5]  = '{1'b1, 32'h0000_0020, BURST_INCR, 32'hFFFF_FFFF, 4'hF, RESP_OKAY};
        vecs[6]  = '{1'b1, 32'h0000_0020, BURST_INCR, 32'h1234_5678, 4'h5, RESP_OKAY};
        vecs[7]  = '{1'b0, 32'h0000_0020, BURST_INCR, 32'hFF34_FF78, 4'h0, RESP_OKAY};
        vecs[8]  = '{1'b1, 32'h0000_0024, BURST_FIXED, 32'h0BAD_F00D, 4'hF, RESP_OKAY};
        vecs[9]  = '{1'b1, 32'h0000_0024, BURST_INCR, 32'h1111_1111, 4'h0, RESP_OKAY};
        vecs[10] = '{1'b0, 32'h0000_0024, BURST_INCR, 32'h0BAD_F00D, 4'h0, RESP_OKAY};
        vecs[11] = '{1'b1, 32'h0000_0FFC, BURST_INCR, 32'hCAFE_F00D, 4'hF, RESP_OKAY};
        vecs[12] = '{1'b0, 32'h0000_0FFC, BURST_INCR, 32'hCAFE_F00D, 4'h0, RESP_OKAY};
        repeat (3) @(negedge clk);
        check("reset_outputs", all_out, 50'd0);
        rst_n = 1;
        @(negedge clk);
        check("post_reset_ready", {o_awready, o_arready, o_wready, o_bvalid, o_rvalid}, 5'b11000);

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].wr) begin
                wbuf[0] = vecs[v].data;
                do_write($sformatf("vec%0d", v), 4'(v), vecs[v].addr, 8'd0, vecs[v].burst,
                         vecs[v].strb, 16'h1, 0, vecs[v].resp);
            end else begin
                ebuf[0] = vecs[v].data;
                do_read($sformatf("vec%0d", v), 4'(v), vecs[v].addr, 8'd0, vecs[v].burst,
                        vecs[v].resp, -1, 0);
            end
        end

        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h11 * (i + 1); ebuf[i] = wbuf[i]; end
        do_write("incr_w", 4'd5, 32'h100, 8'd3, BURST_INCR, 4'hF, 16'h8, 0, RESP_OKAY);
        do_read("incr_r", 4'd5, 32'h100, 8'd3, BURST_INCR, RESP_OKAY, -1, 0);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hD000_0010 + 32'(4 * i);
        do_write("wrap_fill", 4'd2, 32'h10, 8'd3, BURST_INCR, 4'hF, 16'h8, 0, RESP_OKAY);
        ebuf[0] = 32'hD000_0018; ebuf[1] = 32'hD000_001C; ebuf[2] = 32'hD000_0010; ebuf[3] = 32'hD000_0014;
        do_read("wrap_r", 4'd2, 32'h18, 8'd3, BURST_WRAP, RESP_OKAY, -1, 0);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hE0 + 32'(i);
        do_write("wlast_early", 4'd3, 32'h50, 8'd3, BURST_INCR, 4'hF, 16'b1010, 0, RESP_SLVERR);
        do_write("wlast_miss", 4'd4, 32'h70, 8'd1, BURST_INCR, 4'hF, 16'b0000, 0, RESP_SLVERR);

        for (int i = 0; i < 3; i++) begin wbuf[i] = 32'(i + 1); ebuf[i] = wbuf[i]; end
        do_write("wrap_len2_w", 4'd6, 32'h44, 8'd2, BURST_WRAP, 4'hF, 16'h4, 0, RESP_SLVERR);
        do_read("wrap_len2_incr", 4'd6, 32'h44, 8'd2, BURST_INCR, RESP_OKAY, -1, 0);
        do_read("wrap_len2_r", 4'd6, 32'h44, 8'd2, BURST_WRAP, RESP_SLVERR, -1, 0);

        for (int i = 0; i < 4; i++) ebuf[i] = 32'h11 * (i + 1);
        do_read("bp_r", 4'd5, 32'h100, 8'd3, BURST_INCR, RESP_OKAY, 1, 5);
        wbuf[0] = 32'h5A5A_0060;
        do_write("bp_w", 4'd7, 32'h60, 8'd0, BURST_INCR, 4'hF, 16'h1, 5, RESP_OKAY);

        for (int i = 0; i < 16; i++) begin wbuf[i] = 32'h0101_0101 * (i + 1); ebuf[i] = wbuf[i]; end
        do_write("stream_w", 4'd9, 32'h200, 8'd15, BURST_INCR, 4'hF, 16'h8000, 0, RESP_OKAY);
        do_read("stream_r", 4'd9, 32'h200, 8'd15, BURST_INCR, RESP_OKAY, -1, 0);

        i_awid = 4'd1; i_awaddr = 32'h300; i_awlen = 8'd3; i_awburst = BURST_INCR; i_awvalid = 1;
        @(negedge clk);
        i_awvalid = 0;
        i_wdata = 32'hAAAA_0001; i_wstrobe = 4'hF; i_wlast = 0; i_wvalid = 1;
        @(negedge clk);
        i_wdata = 32'hAAAA_0002;
        #2 rst_n = 0;
        #1 check("midburst_reset_outputs", all_out, 50'd0);
        i_wvalid = 0;
        repeat (2) @(negedge clk);
        check("reset_hold_outputs", all_out, 50'd0);
        rst_n = 1;
        @(negedge clk);
        check("reset_recover", {o_awready, o_wready, o_bvalid}, 3'b100);
        wbuf[0] = 32'hBBBB_0300; wbuf[1] = 32'hBBBB_0304; ebuf[0] = wbuf[0]; ebuf[1] = wbuf[1];
        do_write("after_reset_w", 4'd8, 32'h300, 8'd1, BURST_INCR, 4'hF, 16'h2, 0, RESP_OKAY);
        do_read("after_reset_r", 4'd8, 32'h300, 8'd1, BURST_INCR, RESP_OKAY, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
